reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- 2-wide in-order Reorder Buffer (ROB) sitting directly downstream of the rename stage.
- Accepts up to two rename_struct entries per cycle and tracks their completion from execute.
- Retires up to two oldest completed entries per cycle, in program order.
- Returns each retired entry's old physical destination register to rename's free pool via o_free_PRegs.

Parameters:
- DEPTH, 16, number of ROB entries; must be a power of two, at least 4.
- IDX_W, $clog2(DEPTH), width of a ROB index.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_alloc_valid  input  [0:1] x 1  slot i of i_rename_data carries a real instruction.
- i_rename_data  input  [0:1] x rename_struct  renamed instructions from rename.
- o_alloc_ready  output  1  ROB can accept two allocations this cycle.
- o_rob_idx  output  [0:1] x IDX_W  ROB index assigned to slot i (combinational, valid when allocated).
- i_complete_valid  input  [0:1] x 1  execute reports completion on port i.
- i_complete_idx  input  [0:1] x IDX_W  ROB index being completed.
- o_free_PRegs  output  [0:1] x p_reg  PRegs released this cycle; 0 means none.
- o_retire_count  output  2  number of entries retired at the last edge (0..2).
- o_count  output  IDX_W+1  current occupancy.
- o_empty  output  1  occupancy is zero.

Behaviour:
- Reset (async, i_rst=1):
  - All entry valid/done bits cleared; head=tail=0; count=0.
  - o_free_PRegs={0,0}; o_retire_count=0; o_alloc_ready=1; o_empty=1.
  - Reset asserted mid-operation discards all in-flight entries immediately.
- Entry contents: valid, done, PRegAddrDst, OldPRegAddrDst, RegWrite.
- Allocation:
  - o_alloc_ready = (count <= DEPTH-2), computed from registered count only; it does not depend on same-cycle retires.
  - Valid slots are ignored when o_alloc_ready=0; upstream must hold them.
  - Valid slots are written at the tail in order, slot 0 before slot 1.
  - If only slot 1 is valid, it takes the tail entry (compaction).
  - o_rob_idx[0]=tail; o_rob_idx[1]=tail+1 if both slots are valid, else tail.
  - Tail advances by the number of allocations, mod DEPTH (wrap).
  - New entries enter with done=0.
- Completion:
  - On each edge where i_complete_valid[i]=1 and entry i_complete_idx[i] is valid, set that entry's done bit.
  - Completion to an invalid entry is ignored.
  - Both ports naming the same index is legal; the result is the same as a single completion.
  - Completion at edge N is eligible to retire at edge N+1. There is no same-edge complete-and-retire.
- Retire:
  - Entry at head retires if valid && done.
  - Entry at head+1 retires only if head retires and head+1 is valid && done.
  - Retired entries are cleared; head advances by the number retired, mod DEPTH.
- o_free_PRegs[k]:
  - Registered on the retire edge; holds for exactly one cycle, then returns to 0.
  - Value = OldPRegAddrDst if RegWrite=1 and PRegAddrDst!=0, else 0.
  - Index k follows retire order.
- o_retire_count is registered alongside o_free_PRegs.
- Occupancy:
  - count_next = count + allocs - retires.
  - Simultaneous allocate and retire in the same cycle is legal, including when the ROB is full (count=DEPTH).
  - In that case retires proceed, and allocation is blocked by o_alloc_ready=0.
- Head never passes tail. When empty, nothing retires even if stale done bits exist; valid gates every check.

Decomposition:
- Shared Types package gains:
  - ROB_DEPTH constant.
  - rob_idx_t typedef.
  - rob_entry struct {valid, done, PRegAddrDst, OldPRegAddrDst, RegWrite}.
- p_reg and rename_struct are reused unchanged.
- One sub-module: rob_retire_select.
  - Purely combinational.
  - Inputs: head and head+1 entries.
  - Outputs: retire mask and free-PReg values.
  - reorder_buffer owns all state: entries, head, tail, count.

Test Plan:
- Reset, then allocate two instructions {Dst=32,Old=5,RegWrite=1} and {Dst=33,Old=6,RegWrite=1} -> o_rob_idx={0,1}, o_count=2, o_empty=0.
- Complete idx 1 only, then idx 0 one cycle later -> nothing retires until the edge after idx 0 completes; then o_free_PRegs={5,6}, o_retire_count=2, and one cycle later o_free_PRegs={0,0}.
- Entry with PRegAddrDst=0 (x0 destination) completes and retires -> o_free_PRegs slot=0, o_retire_count=1.
- Fill to count=16 (DEPTH=16) -> o_alloc_ready=0 and further allocs are ignored; retire 2 and allocate 2 in a loop for 40 cycles -> head/tail wrap, o_rob_idx sequence continues 0..15 mod 16, count stays bounded.
- Only slot 1 valid with tail=7 -> entry written at 7, o_rob_idx[1]=7, tail becomes 8.
- Assert i_rst with 5 entries in flight mid-cycle -> o_count=0, o_empty=1, o_alloc_ready=1 immediately; later completions of old indices cause no retire.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared rename/ROB types: physical register tags, the rename hand-off record
// and the per-entry ROB record, plus small helpers used by the ROB.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
  localparam int PREG_W    = 6;

  typedef logic [PREG_W-1:0]    p_reg;
  typedef logic [ROB_IDX_W-1:0] rob_idx_t;

  typedef struct packed {
    logic RegWrite;
    p_reg PRegAddrDst;
    p_reg OldPRegAddrDst;
  } rename_struct;

  typedef struct packed {
    logic valid;
    logic done;
    p_reg PRegAddrDst;
    p_reg OldPRegAddrDst;
    logic RegWrite;
  } rob_entry;

  function automatic rob_entry new_entry(rename_struct r);
    rob_entry e;
    e.valid          = 1'b1;
    e.done           = 1'b0;
    e.PRegAddrDst    = r.PRegAddrDst;
    e.OldPRegAddrDst = r.OldPRegAddrDst;
    e.RegWrite       = r.RegWrite;
    return e;
  endfunction

  // x0 destinations never took a fresh PReg, so there is nothing to hand back
  function automatic p_reg freed_preg(rob_entry e);
    return (e.RegWrite && e.PRegAddrDst != '0) ? e.OldPRegAddrDst : '0;
  endfunction

endpackage

// File: rtl/reorder_buffer_retire_select.sv
// Retire selection for the two oldest ROB entries: decides which retire this
// edge (strictly in order) and which old PRegs they release.
module rob_retire_select
  import reorder_buffer_pkg::*;
(
  input  rob_entry   i_head_entry,
  input  rob_entry   i_next_entry,
  output logic [1:0] o_retire_mask,
  output p_reg       o_free_PRegs [0:1]
);

  logic w_head_ret;
  logic w_next_ret;

  assign w_head_ret = i_head_entry.valid && i_head_entry.done;
  assign w_next_ret = w_head_ret && i_next_entry.valid && i_next_entry.done;

  assign o_retire_mask   = {w_next_ret, w_head_ret};
  assign o_free_PRegs[0] = w_head_ret ? freed_preg(i_head_entry) : '0;
  assign o_free_PRegs[1] = w_next_ret ? freed_preg(i_next_entry) : '0;

endmodule

// File: rtl/reorder_buffer.sv
// 2-wide in-order reorder buffer: allocates from rename at the tail, marks
// completions from execute, retires up to two done entries from the head.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [0:1]       i_alloc_valid,
  input  rename_struct     i_rename_data [0:1],
  output logic             o_alloc_ready,
  output logic [IDX_W-1:0] o_rob_idx [0:1],
  input  logic [0:1]       i_complete_valid,
  input  logic [IDX_W-1:0] i_complete_idx [0:1],
  output p_reg             o_free_PRegs [0:1],
  output logic [1:0]       o_retire_count,
  output logic [IDX_W:0]   o_count,
  output logic             o_empty
);

  rob_entry         r_entries [DEPTH];
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [IDX_W:0]   r_count;

  logic [0:1]       w_alloc_en;
  logic [1:0]       w_n_alloc;
  logic [1:0]       w_ret_mask;
  logic [1:0]       w_n_ret;
  logic [IDX_W-1:0] w_head_p1;
  logic [IDX_W-1:0] w_slot1_idx;
  p_reg             w_free [0:1];

  // Ready looks only at registered occupancy so it never depends on retires
  assign o_alloc_ready = (r_count <= (IDX_W+1)'(DEPTH - 2));
  assign w_alloc_en    = o_alloc_ready ? i_alloc_valid : 2'b00;
  assign w_n_alloc     = {1'b0, w_alloc_en[0]} + {1'b0, w_alloc_en[1]};
  assign w_n_ret       = {1'b0, w_ret_mask[0]} + {1'b0, w_ret_mask[1]};
  assign w_head_p1     = r_head + IDX_W'(1);

  // A lone slot 1 is compacted onto the tail entry
  assign w_slot1_idx  = (i_alloc_valid[0] && i_alloc_valid[1]) ? r_tail + IDX_W'(1) : r_tail;
  assign o_rob_idx[0] = r_tail;
  assign o_rob_idx[1] = w_slot1_idx;

  assign o_count = r_count;
  assign o_empty = (r_count == '0);

  rob_retire_select u_retire_select (
    .i_head_entry  (r_entries[r_head]),
    .i_next_entry  (r_entries[w_head_p1]),
    .o_retire_mask (w_ret_mask),
    .o_free_PRegs  (w_free)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      o_free_PRegs[0] <= '0;
      o_free_PRegs[1] <= '0;
      o_retire_count  <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (i_complete_valid[k] && r_entries[i_complete_idx[k]].valid)
          r_entries[i_complete_idx[k]].done <= 1'b1;
      end
      if (w_ret_mask[0]) r_entries[r_head]    <= '0;
      if (w_ret_mask[1]) r_entries[w_head_p1] <= '0;
      if (w_alloc_en[0]) r_entries[r_tail]      <= new_entry(i_rename_data[0]);
      if (w_alloc_en[1]) r_entries[w_slot1_idx] <= new_entry(i_rename_data[1]);
      r_head          <= r_head + IDX_W'(w_n_ret);
      r_tail          <= r_tail + IDX_W'(w_n_alloc);
      r_count         <= r_count + (IDX_W+1)'(w_n_alloc) - (IDX_W+1)'(w_n_ret);
      o_free_PRegs[0] <= w_free[0];
      o_free_PRegs[1] <= w_free[1];
      o_retire_count  <= w_n_ret;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: table of hand-computed vectors, then a
// mid-cycle reset sequence and a fill / steady-state wrap sequence.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [0:1]   alloc_valid;
  rename_struct rename_data [0:1];
  logic         alloc_ready;
  logic [3:0]   rob_idx [0:1];
  logic [0:1]   comp_valid;
  logic [3:0]   comp_idx [0:1];
  p_reg         free_pregs [0:1];
  logic [1:0]   retire_count;
  logic [4:0]   count;
  logic         empty;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_alloc_valid    (alloc_valid),
    .i_rename_data    (rename_data),
    .o_alloc_ready    (alloc_ready),
    .o_rob_idx        (rob_idx),
    .i_complete_valid (comp_valid),
    .i_complete_idx   (comp_idx),
    .o_free_PRegs     (free_pregs),
    .o_retire_count   (retire_count),
    .o_count          (count),
    .o_empty          (empty)
  );

  typedef struct {
    logic [0:1]   av;
    rename_struct r0;
    rename_struct r1;
    logic [0:1]   cv;
    int           ci0;
    int           ci1;
    int           e_idx0;
    int           e_idx1;
    int           e_cnt;
    int           e_f0;
    int           e_f1;
    int           e_rc;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic rename_struct mk(int dst, int old, bit rw);
    rename_struct r;
    r.RegWrite       = rw;
    r.PRegAddrDst    = p_reg'(dst);
    r.OldPRegAddrDst = p_reg'(old);
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(logic [0:1] av, rename_struct r0, rename_struct r1,
                       logic [0:1] cv, int ci0, int ci1);
    alloc_valid    = av;
    rename_data[0] = r0;
    rename_data[1] = r1;
    comp_valid     = cv;
    comp_idx[0]    = 4'(ci0);
    comp_idx[1]    = 4'(ci1);
  endtask

  task automatic idle();
    drive(2'b00, mk(0, 0, 0), mk(0, 0, 0), 2'b00, 0, 0);
  endtask

  task automatic post_checks(string tag, int cnt, int f0, int f1, int rc);
    chk({tag, " count"}, int'(count), cnt);
    chk({tag, " empty"}, int'(empty), int'(cnt == 0));
    chk({tag, " ready"}, int'(alloc_ready), int'(cnt <= 14));
    chk({tag, " free0"}, int'(free_pregs[0]), f0);
    chk({tag, " free1"}, int'(free_pregs[1]), f1);
    chk({tag, " retire_count"}, int'(retire_count), rc);
  endtask

  initial begin
    int   h, t, cnt, cp, serial, ret, nalloc, e_f0, e_f1;
    bit   e_ready;
    int   old_of [16];
    string tag;

    vecs[0]  = '{2'b11, mk(32, 5, 1), mk(33, 6, 1), 2'b00, 0, 0, 0, 1, 2, 0, 0, 0};
    vecs[1]  = '{2'b00, mk(0, 0, 0),  mk(0, 0, 0),  2'b10, 1, 0, 2, 2, 2, 0, 0, 0};
    vecs[2]  = '{2'b00, mk(0, 0, 0),  mk(0, 0, 0),  2'b10, 0, 0, 2, 2, 2, 0, 0, 0};
    vecs[3]  = '{2'b00, mk(0, 0, 0),  mk(0, 0, 0),  2'b00, 0, 0, 2, 2, 0, 5, 6, 2};
    vecs[4]  = '{2'b00, mk(0, 0, 0),  mk(0, 0, 0),  2'b00, 0, 0, 2, 2, 0, 0, 0, 0};
    vecs[5]  = '{2'b10, mk(0, 7, 1),  mk(0, 0, 0),  2'b00, 0, 0, 2, 2, 1, 0, 0, 0};
    vecs[6]  = '{2'b00, mk(0, 0, 0),  mk(0, 0, 0),  2'b11, 2, 2, 3, 3, 1, 0, 0, 0};
    vecs[7]  = '{2'b00, mk(0, 0, 0),  mk(0, 0, 0),  2'b00, 0, 0, 3, 3, 0, 0, 0, 1};
    vecs[8]  = '{2'b11, mk(34, 8, 0), mk(35, 10, 1), 2'b00, 0, 0, 3, 4, 2, 0, 0, 0};
    vecs[9]  = '{2'b00, mk(0, 0, 0),  mk(0, 0, 0),  2'b11, 4, 9, 5, 5, 2, 0, 0, 0};
    vecs[10] = '{2'b00, mk(0, 0, 0),  mk(0, 0, 0),  2'b00, 0, 0, 5, 5, 2, 0, 0, 0};
    vecs[11] = '{2'b00, mk(0, 0, 0),  mk(0, 0, 0),  2'b10, 3, 0, 5, 5, 2, 0, 0, 0};
    vecs[12] = '{2'b00, mk(0, 0, 0),  mk(0, 0, 0),  2'b00, 0, 0, 5, 5, 0, 0, 10, 2};
    vecs[13] = '{2'b11, mk(36, 11, 1), mk(37, 12, 1), 2'b00, 0, 0, 5, 6, 2, 0, 0, 0};
    vecs[14] = '{2'b01, mk(0, 0, 0),  mk(38, 13, 1), 2'b00, 0, 0, 7, 7, 3, 0, 0, 0};
    vecs[15] = '{2'b10, mk(39, 14, 1), mk(0, 0, 0),  2'b11, 5, 6, 8, 8, 4, 0, 0, 0};
    vecs[16] = '{2'b00, mk(0, 0, 0),  mk(0, 0, 0),  2'b10, 7, 0, 9, 9, 2, 11, 12, 2};
    vecs[17] = '{2'b00, mk(0, 0, 0),  mk(0, 0, 0),  2'b00, 0, 0, 9, 9, 1, 13, 0, 1};
    vecs[18] = '{2'b11, mk(41, 16, 1), mk(42, 17, 1), 2'b00, 0, 0, 9, 10, 3, 0, 0, 0};
    vecs[19] = '{2'b11, mk(43, 18, 1), mk(44, 19, 1), 2'b10, 8, 0, 11, 12, 5, 0, 0, 0};

    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    post_checks("reset", 0, 0, 0, 0);
    rst = 1'b0;

    for (int v = 0; v < NV; v++) begin
      tag = $sformatf("vec%0d", v);
      drive(vecs[v].av, vecs[v].r0, vecs[v].r1, vecs[v].cv, vecs[v].ci0, vecs[v].ci1);
      #1;
      chk({tag, " rob_idx0"}, int'(rob_idx[0]), vecs[v].e_idx0);
      chk({tag, " rob_idx1"}, int'(rob_idx[1]), vecs[v].e_idx1);
      @(posedge clk);
      #1;
      idle();
      post_checks(tag, vecs[v].e_cnt, vecs[v].e_f0, vecs[v].e_f1, vecs[v].e_rc);
    end

    // Five entries in flight (head 8 already done): reset lands mid-cycle
    #2 rst = 1'b1;
    #1;
    post_checks("midreset", 0, 0, 0, 0);
    chk("midreset rob_idx0", int'(rob_idx[0]), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(2'b00, mk(0, 0, 0), mk(0, 0, 0), 2'b11, 8, 9);
    @(posedge clk);
    #1;
    idle();
    post_checks("stale_comp", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    post_checks("stale_retire", 0, 0, 0, 0);

    h = 0; t = 0; cnt = 0; cp = 0; serial = 0;
    for (int j = 0; j < 8; j++) begin
      tag = $sformatf("fill%0d", j);
      drive(2'b11, mk(10 + t, t + 1, 1), mk(11 + t, t + 2, 1), 2'b00, 0, 0);
      old_of[t] = t + 1;
      old_of[t + 1] = t + 2;
      #1;
      chk({tag, " rob_idx0"}, int'(rob_idx[0]), t);
      chk({tag, " rob_idx1"}, int'(rob_idx[1]), t + 1);
      @(posedge clk);
      #1;
      idle();
      t = (t + 2) % 16;
      cnt += 2;
      post_checks(tag, cnt, 0, 0, 0);
    end

    // Keep pushing two per cycle while completing the two oldest undone
    for (int it = 0; it < 40; it++) begin
      tag = $sformatf("wrap%0d", it);
      e_ready = (cnt <= 14);
      ret     = (it > 0) ? 2 : 0;
      e_f0    = (ret > 0) ? old_of[h] : 0;
      e_f1    = (ret > 0) ? old_of[(h + 1) % 16] : 0;
      drive(2'b11, mk(1 + (serial % 60), 20 + (serial % 40), 1),
            mk(1 + ((serial + 1) % 60), 20 + ((serial + 1) % 40), 1),
            2'b11, cp, (cp + 1) % 16);
      #1;
      chk({tag, " pre_ready"}, int'(alloc_ready), int'(e_ready));
      chk({tag, " rob_idx0"}, int'(rob_idx[0]), t);
      chk({tag, " rob_idx1"}, int'(rob_idx[1]), (t + 1) % 16);
      nalloc = e_ready ? 2 : 0;
      if (e_ready) begin
        old_of[t] = 20 + (serial % 40);
        old_of[(t + 1) % 16] = 20 + ((serial + 1) % 40);
        serial += 2;
      end
      @(posedge clk);
      #1;
      idle();
      t   = (t + nalloc) % 16;
      h   = (h + ret) % 16;
      cp  = (cp + 2) % 16;
      cnt = cnt + nalloc - ret;
      post_checks(tag, cnt, e_f0, e_f1, ret);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
